// File: rtl/result_mem_responder.sv
// result_mem_responder: 64-entry result buffer with a valid bitmap, one-cycle registered reads, fill tracking and sticky error flags.
// Defining RESULT_MEM_PARITY_EN adds a per-entry even-parity bit that is checked on every read.
module result_mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN_writeMem,
  input  logic [ADDR_W-1:0] writeMem_addr,
  input  logic [DATA_W-1:0] writeMem_val,
  input  logic              EN_readMem,
  input  logic [ADDR_W-1:0] readMem_addr,
  output logic [DATA_W-1:0] readMem_val,
  output logic              readMem_vld,
  input  logic              clear,
  output logic [ADDR_W:0]   wr_count,
  output logic [1:0]        fill_state,
  output logic              rd_unwritten_err,
  output logic              overwrite_err,
  output logic              parity_err
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] memData [DEPTH];
  logic [DEPTH-1:0]  validBits;
  logic              wrEff;
  logic              rdBypass;
  logic              rdHit;

  // A write that coincides with clear is dropped entirely.
  assign wrEff    = EN_writeMem && !clear;
  // A same-cycle write to the read address is forwarded (write-first).
  assign rdBypass = wrEff && (readMem_addr == writeMem_addr);
  assign rdHit    = rdBypass || validBits[readMem_addr];

  // wr_count only reaches DEPTH when its top bit is set.
  assign fill_state = wr_count[ADDR_W] ? 2'b10 : (wr_count == '0) ? 2'b00 : 2'b01;

  // Storage is not reset; the valid bitmap hides any stale contents.
  always_ff @(posedge clk) begin
    if (wrEff) memData[writeMem_addr] <= writeMem_val;
  end

  // Registered read port: the response appears one cycle after the request, and invalid entries read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readMem_val <= '0;
      readMem_vld <= 1'b0;
    end else begin
      readMem_vld <= EN_readMem;
      if (EN_readMem) readMem_val <= rdBypass ? writeMem_val : rdHit ? memData[readMem_addr] : '0;
    end
  end

  // Valid bitmap, distinct-entry count and sticky flags; clear wipes them all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validBits        <= '0;
      wr_count         <= '0;
      rd_unwritten_err <= 1'b0;
      overwrite_err    <= 1'b0;
    end else if (clear) begin
      validBits        <= '0;
      wr_count         <= '0;
      rd_unwritten_err <= 1'b0;
      overwrite_err    <= 1'b0;
    end else begin
      if (wrEff) begin
        validBits[writeMem_addr] <= 1'b1;
        if (validBits[writeMem_addr]) overwrite_err <= 1'b1;
        else wr_count <= wr_count + 1'b1;
      end
      if (EN_readMem && !rdHit) rd_unwritten_err <= 1'b1;
    end
  end

`ifdef RESULT_MEM_PARITY_EN
  logic parBits [DEPTH];

  // Even-parity bit stored alongside each entry.
  always_ff @(posedge clk) begin
    if (wrEff) parBits[writeMem_addr] <= ^writeMem_val;
  end

  // Parity is checked only on stored valid entries, so the flag rises with readMem_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else if (clear) parity_err <= 1'b0;
    else if (EN_readMem && !rdBypass && validBits[readMem_addr] &&
             ((^memData[readMem_addr]) != parBits[readMem_addr])) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_result_mem_responder.sv
// tb_result_mem_responder: directed stimulus with a read-data scoreboard checked by an independent monitor.
module tb_result_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        EN_writeMem = 1'b0;
  logic [5:0]  writeMem_addr = '0;
  logic [31:0] writeMem_val = '0;
  logic        EN_readMem = 1'b0;
  logic [5:0]  readMem_addr = '0;
  logic [31:0] readMem_val;
  logic        readMem_vld;
  logic        clear = 1'b0;
  logic [6:0]  wr_count;
  logic [1:0]  fill_state;
  logic        rd_unwritten_err;
  logic        overwrite_err;
  logic        parity_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb [$];

  result_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
    .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
    .readMem_val(readMem_val), .readMem_vld(readMem_vld),
    .clear(clear), .wr_count(wr_count), .fill_state(fill_state),
    .rd_unwritten_err(rd_unwritten_err), .overwrite_err(overwrite_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every read response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && readMem_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got vld=1 with data 0x%0h expected no response", readMem_val);
      end else begin
        chk("rd_data", {32'd0, readMem_val}, {32'd0, sb.pop_front()});
      end
    end
  end

  task automatic op(input logic we, input logic [5:0] wa, input logic [31:0] wv,
                    input logic re, input logic [5:0] ra, input logic [31:0] rexp, input logic clr);
    @(negedge clk);
    EN_writeMem = we; writeMem_addr = wa; writeMem_val = wv;
    EN_readMem = re; readMem_addr = ra; clear = clr;
    if (re) sb.push_back(rexp);
  endtask

  task automatic idle();
    @(negedge clk);
    EN_writeMem = 1'b0; EN_readMem = 1'b0; clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_val", readMem_val, 0);
    chk("rst_vld", readMem_vld, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_fill", fill_state, 2'b00);
    chk("rst_flags", {rd_unwritten_err, overwrite_err, parity_err}, 3'b000);
    rst_n = 1'b1;

    // Write then read addr 5
    op(1, 5, 32'h0000_1234, 0, 0, 0, 0);
    op(0, 0, 0, 1, 5, 32'h0000_1234, 0);
    idle();
    chk("t1_count", wr_count, 1);
    chk("t1_fill", fill_state, 2'b01);
    idle(); idle();
    chk("t1_hold", readMem_val, 32'h0000_1234);
    chk("t1_vld_low", readMem_vld, 0);
    op(0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("clr_count", wr_count, 0);
    chk("clr_fill", fill_state, 2'b00);

    // Same-cycle write/read bypass on empty buffer
    op(1, 7, 32'hDEAD_BEEF, 1, 7, 32'hDEAD_BEEF, 0);
    idle();
    chk("t3_unwr", rd_unwritten_err, 0);
    chk("t3_count", wr_count, 1);

    // Read of never-written entry, then clear
    op(0, 0, 0, 1, 40, 0, 0);
    idle();
    chk("t4_unwr", rd_unwritten_err, 1);
    op(0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("t4_clr_unwr", rd_unwritten_err, 0);
    chk("t4_clr_count", wr_count, 0);

    // Clear beats a coincident write
    op(1, 3, 32'h0000_0055, 0, 0, 0, 1);
    idle();
    chk("t5_count", wr_count, 0);
    op(0, 0, 0, 1, 3, 0, 0);
    idle();
    chk("t5_unwr", rd_unwritten_err, 1);
    op(0, 0, 0, 0, 0, 0, 1);

    // Fill every entry, then overwrite when full
    for (int a = 0; a < 64; a++) op(1, a[5:0], a * 3, 0, 0, 0, 0);
    idle();
    chk("t6_count", wr_count, 64);
    chk("t6_fill", fill_state, 2'b10);
    chk("t6_ovw0", overwrite_err, 0);
    op(1, 10, 32'h0000_0099, 0, 0, 0, 0);
    idle();
    chk("t6_ovw", overwrite_err, 1);
    chk("t6_count_sat", wr_count, 64);
    chk("t6_fill_sat", fill_state, 2'b10);
    op(0, 0, 0, 1, 10, 32'h0000_0099, 0);
    op(0, 0, 0, 1, 63, 189, 0);
    op(0, 0, 0, 1, 20, 60, 1);
    op(0, 0, 0, 1, 20, 0, 0);
    idle();
    chk("t6_clr_count", wr_count, 0);
    chk("t6_clr_ovw", overwrite_err, 0);
    chk("t6_unwr", rd_unwritten_err, 1);
    chk("t6_parity", parity_err, 0);

    // Reset lands while a read is in flight
    op(1, 9, 32'h0000_0777, 0, 0, 0, 0);
    op(0, 0, 0, 1, 9, 32'h0000_0777, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t7_vld", readMem_vld, 0);
    chk("t7_val", readMem_val, 0);
    chk("t7_parity", parity_err, 0);
    idle();
    rst_n = 1'b1;
    idle();
    chk("t7_vld_post", readMem_vld, 0);
    chk("t7_count", wr_count, 0);
    op(0, 0, 0, 1, 9, 0, 0);
    idle(); idle();
    chk("t7_unwr", rd_unwritten_err, 1);
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/result_mem_responder.md
RESULT_MEM_RESPONDER -- requirements
Module: result_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the entry data width.
REQ-002 SHALL have parameter ADDR_W, default 6, the address width; DEPTH = 2**ADDR_W = 64 entries.
REQ-003 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-005 SHALL have port EN_writeMem, input, 1, write strobe.
REQ-006 SHALL have port writeMem_addr, input, ADDR_W, write address.
REQ-007 SHALL have port writeMem_val, input, DATA_W, write data.
REQ-008 SHALL have port EN_readMem, input, 1, read strobe.
REQ-009 SHALL have port readMem_addr, input, ADDR_W, read address.
REQ-010 SHALL have port readMem_val, output, DATA_W, registered read data.
REQ-011 SHALL have port readMem_vld, output, 1, read-data-valid pulse.
REQ-012 SHALL have port clear, input, 1, synchronous buffer invalidate.
REQ-013 SHALL have port wr_count, output, ADDR_W+1, number of distinct valid entries (0..64).
REQ-014 SHALL have port fill_state, output, 2, fill status: 00 EMPTY, 01 FILLING, 10 FULL.
REQ-015 SHALL have port rd_unwritten_err, output, 1, sticky flag for a read of an invalid entry.
REQ-016 SHALL have port overwrite_err, output, 1, sticky flag for a write to an already-valid entry.
REQ-017 SHALL have port parity_err, output, 1, sticky flag for a read parity mismatch.

Function
REQ-018 SHALL hold DEPTH x DATA_W storage plus a DEPTH-bit valid bitmap.
REQ-019 SHALL, on EN_writeMem, write writeMem_val to the addressed entry and set its valid bit in the same edge.
REQ-020 SHALL increment wr_count only when the written entry was invalid; otherwise SHALL set overwrite_err and leave wr_count unchanged.
REQ-021 SHALL, for EN_readMem in cycle N, drive readMem_val and assert readMem_vld for exactly one cycle in N+1.
REQ-022 SHALL hold readMem_val at its last value when no read is issued; readMem_vld SHALL be 0.
REQ-023 SHALL, for a read and a write to the same address in the same cycle, return the new write data (write-first bypass) with no rd_unwritten_err.
REQ-024 SHALL, on a read of an invalid entry, return all-zero data with readMem_vld=1 and set rd_unwritten_err.
REQ-025 SHALL set fill_state as follows: EMPTY when wr_count=0, FULL when wr_count=DEPTH, otherwise FILLING.
REQ-026 SHALL treat back-to-back reads and writes every cycle as legal, with no stall and no ready output.
REQ-027 SHALL, on clear, zero the valid bitmap, wr_count and all sticky flags at the next edge; storage contents SHALL be left unchanged.
REQ-028 SHALL give clear priority over a write in the same cycle; that write SHALL be dropped.
REQ-029 SHALL serve a read issued in the same cycle as clear from the pre-clear state.
REQ-030 SHALL set overwrite_err on a write to a valid entry when FULL, with wr_count staying at 64; wr_count SHALL never wrap.

Reset
REQ-031 SHALL, on rst_n low, immediately zero readMem_val, readMem_vld, wr_count, the valid bitmap and all sticky flags, and set fill_state to EMPTY.
REQ-032 SHALL not reset storage; stale data SHALL be unobservable because the bitmap masks it (REQ-024).
REQ-033 SHALL discard any read in flight when reset asserts mid-operation; readMem_vld SHALL be 0 on the first edge after reset release.

Configuration
REQ-034 SHALL, with RESULT_MEM_PARITY_EN defined, store an even-parity bit per entry on write, recompute parity on read, and set parity_err on mismatch in the cycle readMem_vld asserts.
REQ-035 SHALL, without RESULT_MEM_PARITY_EN, include no parity storage and tie parity_err to 0.

Verification
REQ-036 SHALL cover: write addr 5 = 0x0000_1234, then read addr 5 -> readMem_val=0x0000_1234, readMem_vld high one cycle later, wr_count=1, fill_state=01.
REQ-037 SHALL cover: write addresses 0..63 with value = addr*3 -> wr_count=64, fill_state=10; then write addr 10 again -> overwrite_err=1, wr_count=64.
REQ-038 SHALL cover: same-cycle write addr 7 = 0xDEAD_BEEF and read addr 7 on an empty buffer -> next-cycle readMem_val=0xDEAD_BEEF, rd_unwritten_err=0.
REQ-039 SHALL cover: read of never-written addr 40 -> readMem_val=0, readMem_vld=1, rd_unwritten_err=1; then clear -> rd_unwritten_err=0, wr_count=0.
REQ-040 SHALL cover: clear coincident with a write to addr 3 -> wr_count=0, and a later read of addr 3 -> data 0 with rd_unwritten_err=1.
REQ-041 SHALL cover: reset asserted in the cycle after a read is issued -> readMem_vld=0, readMem_val=0, and parity_err=0 under both macro settings.
